// File: rtl/bbox_span_iterator_if.sv
// Job-control and beat handshake bundle for the bounding-box span iterator.
interface bbox_span_iterator_if #(
  parameter int XLEN  = 15,
  parameter int LANES = 4
);
  logic                 i_start;
  logic                 i_abort;
  logic                 i_serpentine;
  logic signed [XLEN:0] i_bbx0, i_bbx1, i_bby0, i_bby1;
  logic signed [XLEN:0] i_clx0, i_clx1, i_cly0, i_cly1;
  logic                 i_ready;
  logic                 o_busy;
  logic                 o_valid;
  logic signed [XLEN:0] o_x;
  logic signed [XLEN:0] o_y;
  logic [LANES-1:0]     o_mask;
  logic                 o_last;
  logic                 o_done;

  modport master (
    output i_start, i_abort, i_serpentine,
    output i_bbx0, i_bbx1, i_bby0, i_bby1,
    output i_clx0, i_clx1, i_cly0, i_cly1,
    output i_ready,
    input  o_busy, o_valid, o_x, o_y, o_mask, o_last, o_done
  );

  modport slave (
    input  i_start, i_abort, i_serpentine,
    input  i_bbx0, i_bbx1, i_bby0, i_bby1,
    input  i_clx0, i_clx1, i_cly0, i_cly1,
    input  i_ready,
    output o_busy, o_valid, o_x, o_y, o_mask, o_last, o_done
  );
endinterface

// File: rtl/bbox_span_iterator.sv
// Clips a bbox against a scissor rectangle and walks it in LANES-aligned pixel
// groups (raster or serpentine), one group per handshake beat with a lane mask.
module bbox_span_iterator #(
  parameter int XLEN  = 15,
  parameter int LANES = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  bbox_span_iterator_if.slave  bus
);
  localparam int W = XLEN + 1;
  localparam logic signed [W-1:0] STEP  = W'(LANES);
  localparam logic signed [W-1:0] ALIGN = ~(W'(LANES - 1));

  typedef enum logic [1:0] {IDLE, SETUP, RUN} state_t;
  state_t state, state_nxt;

  logic signed [W-1:0] bbx0_q, bbx1_q, bby0_q, bby1_q;
  logic signed [W-1:0] clx0_q, clx1_q, cly0_q, cly1_q;
  logic                serp_q;
  logic signed [W-1:0] cx0_q, cx1_q, cy1_q, ax0_q, ax1_q;
  logic signed [W-1:0] x_q, y_q;
  logic                odd_q;
  logic                done_q;

  logic signed [W-1:0] cx0_c, cx1_c, cy0_c, cy1_c;
  logic                empty_c;
  logic                run, hs, row_end, last_c;
  logic                load, init, fin_empty, fin_job;
  logic signed [W:0]   x_e, cx0_e, cx1_e;
  logic [LANES-1:0]    mask_c;

  assign cx0_c   = (bbx0_q > clx0_q) ? bbx0_q : clx0_q;
  assign cx1_c   = (bbx1_q < clx1_q) ? bbx1_q : clx1_q;
  assign cy0_c   = (bby0_q > cly0_q) ? bby0_q : cly0_q;
  assign cy1_c   = (bby1_q < cly1_q) ? bby1_q : cly1_q;
  assign empty_c = (cx0_c > cx1_c) || (cy0_c > cy1_c);

  assign run     = (state == RUN);
  assign hs      = run && bus.i_ready;
  // odd_q only ever toggles in serpentine mode, so raster rows always end at ax1
  assign row_end = (x_q == (odd_q ? ax0_q : ax1_q));
  assign last_c  = run && row_end && (y_q == cy1_q);

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    init      = 1'b0;
    fin_empty = 1'b0;
    fin_job   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_start) begin
          state_nxt = SETUP;
          load      = 1'b1;
        end
      end
      SETUP: begin
        if (bus.i_abort) begin
          state_nxt = IDLE;
        end else if (empty_c) begin
          state_nxt = IDLE;
          fin_empty = 1'b1;
        end else begin
          state_nxt = RUN;
          init      = 1'b1;
        end
      end
      RUN: begin
        if (bus.i_abort) begin
          state_nxt = IDLE;
        end else if (hs && last_c) begin
          state_nxt = IDLE;
          fin_job   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bbx0_q <= '0; bbx1_q <= '0; bby0_q <= '0; bby1_q <= '0;
      clx0_q <= '0; clx1_q <= '0; cly0_q <= '0; cly1_q <= '0;
      serp_q <= 1'b0;
      cx0_q  <= '0; cx1_q <= '0; cy1_q <= '0; ax0_q <= '0; ax1_q <= '0;
      x_q    <= '0; y_q   <= '0;
      odd_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= fin_empty | fin_job;
      if (load) begin
        bbx0_q <= bus.i_bbx0; bbx1_q <= bus.i_bbx1;
        bby0_q <= bus.i_bby0; bby1_q <= bus.i_bby1;
        clx0_q <= bus.i_clx0; clx1_q <= bus.i_clx1;
        cly0_q <= bus.i_cly0; cly1_q <= bus.i_cly1;
        serp_q <= bus.i_serpentine;
      end
      if (init) begin
        cx0_q <= cx0_c;
        cx1_q <= cx1_c;
        cy1_q <= cy1_c;
        ax0_q <= cx0_c & ALIGN;
        ax1_q <= cx1_c & ALIGN;
        x_q   <= cx0_c & ALIGN;
        y_q   <= cy0_c;
        odd_q <= 1'b0;
      end else if (hs && !last_c) begin
        if (row_end) begin
          y_q <= y_q + W'(1);
          if (serp_q) odd_q <= ~odd_q;
          else        x_q   <= ax0_q;
        end else begin
          x_q <= odd_q ? (x_q - STEP) : (x_q + STEP);
        end
      end
    end
  end

  // one extra bit so lane positions near the coordinate maximum cannot wrap
  assign x_e   = {x_q[W-1], x_q};
  assign cx0_e = {cx0_q[W-1], cx0_q};
  assign cx1_e = {cx1_q[W-1], cx1_q};

  always_comb begin
    mask_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      mask_c[i] = ((x_e + $signed((W+1)'(i))) >= cx0_e) &&
                  ((x_e + $signed((W+1)'(i))) <= cx1_e);
    end
  end

  assign bus.o_busy  = (state != IDLE);
  assign bus.o_valid = run;
  assign bus.o_x     = x_q;
  assign bus.o_y     = y_q;
  assign bus.o_mask  = run ? mask_c : '0;
  assign bus.o_last  = last_c;
  assign bus.o_done  = done_q;
endmodule
